// File: rtl/psk_symbol_framer_if.sv
// Byte/symbol stream link (tdata/tvalid/tready/tlast/tuser) with producer and consumer views.
interface psk_symbol_framer_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/psk_symbol_framer.sv
// Frames a payload byte stream with a BPSK preamble and serialises it MSB-first
// into BPSK (1-bit) or QPSK (2-bit) symbols, one per modulator take strobe.
module psk_symbol_framer #(
  parameter int unsigned             BYTES        = 1,
  parameter int unsigned             PREAMBLE_LEN = 16,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE     = 16'hAAAA
) (
  input  logic                clk_16M384,
  input  logic                rst_n_16M384,
  input  logic                cfg_is_bpsk,
  psk_symbol_framer_if.slave  s_axis,
  psk_symbol_framer_if.master m_axis,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun
);

  localparam int unsigned       DATA_W    = BYTES * 8;
  localparam int unsigned       PRE_CW    = (PREAMBLE_LEN > 2) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PRE_CW-1:0] PRE_LAST  = PRE_CW'(PREAMBLE_LEN - 1);
  localparam logic [2:0]        BPSK_LAST = 3'd7;
  localparam logic [2:0]        QPSK_LAST = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_LOAD,
    S_PAY
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [PRE_CW-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        sym_cnt_q, sym_cnt_d;
  logic              last_q, last_d;

  logic [1:0]        m_sym_q, m_sym_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              m_tlast_q, m_tlast_d;
  logic              m_tuser_q, m_tuser_d;
  logic              s_tready_q, s_tready_d;
  logic              busy_q, busy_d;

  logic              xfer;
  logic              sym_final;
  logic [PRE_CW-1:0] pre_idx;
  logic              unused_s_tuser;

  assign xfer           = m_tvalid_q && m_axis.tready;
  assign sym_final      = (sym_cnt_q == (mode_q ? BPSK_LAST : QPSK_LAST));
  assign unused_s_tuser = s_axis.tuser;

  // State register plus registered copies of every stream-facing output.
  always_ff @(posedge clk_16M384) begin
    if (!rst_n_16M384) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      pre_cnt_q  <= '0;
      sh_q       <= '0;
      sym_cnt_q  <= '0;
      last_q     <= 1'b0;
      m_sym_q    <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      s_tready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pre_cnt_q  <= pre_cnt_d;
      sh_q       <= sh_d;
      sym_cnt_q  <= sym_cnt_d;
      last_q     <= last_d;
      m_sym_q    <= m_sym_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      s_tready_q <= s_tready_d;
      busy_q     <= busy_d;
    end
  end

  // Next state, then outputs decoded from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pre_cnt_d  = pre_cnt_q;
    sh_d       = sh_q;
    sym_cnt_d  = sym_cnt_q;
    last_d     = last_q;
    m_sym_d    = 2'b00;
    m_tvalid_d = 1'b0;
    m_tlast_d  = 1'b0;
    m_tuser_d  = 1'b0;
    s_tready_d = 1'b0;
    busy_d     = 1'b0;
    pre_idx    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (s_axis.tvalid) begin
          mode_d    = cfg_is_bpsk;
          pre_cnt_d = '0;
          state_d   = S_PRE;
        end
      end
      S_PRE: begin
        if (xfer) begin
          if (pre_cnt_q == PRE_LAST) begin
            state_d = S_LOAD;
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_CW'(1);
          end
        end
      end
      S_LOAD: begin
        if (s_axis.tvalid) begin
          sh_d      = s_axis.tdata[7:0];
          last_d    = s_axis.tlast;
          sym_cnt_d = 3'd0;
          state_d   = S_PAY;
        end
      end
      S_PAY: begin
        if (xfer) begin
          sh_d      = mode_q ? {sh_q[6:0], 1'b0} : {sh_q[5:0], 2'b00};
          sym_cnt_d = sym_cnt_q + 3'd1;
          if (sym_final) begin
            state_d = last_q ? S_IDLE : S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    s_tready_d = (state_d == S_LOAD);
    m_tvalid_d = (state_d == S_PRE) || (state_d == S_PAY);

    if (state_d == S_PRE) begin
      pre_idx   = PRE_LAST - pre_cnt_d;
      m_sym_d   = {PREAMBLE[pre_idx], 1'b0};
      m_tuser_d = 1'b1;
    end else if (state_d == S_PAY) begin
      m_sym_d   = mode_d ? {sh_d[7], 1'b0} : sh_d[7:6];
      m_tuser_d = mode_d;
      m_tlast_d = last_d && (sym_cnt_d == (mode_d ? BPSK_LAST : QPSK_LAST));
    end
  end

  assign m_axis.tdata  = DATA_W'(m_sym_q);
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  assign m_axis.tuser  = m_tuser_q;
  assign s_axis.tready = s_tready_q;
  assign busy          = busy_q;

  // Status strobes coincide with the take strobe they report on.
  assign frame_done = xfer && m_tlast_q;
  assign underrun   = (state_q == S_LOAD) && m_axis.tready;

endmodule
